// File: rtl/wb_arbiter_nto1_pkg.sv
// Shared types and default Wishbone widths for the N:1 arbiter and its picker.
package wb_arb_pkg;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1
`ifdef WB_ARB_TIMEOUT_EN
    ,
    ABORT = 2'd2
`endif
  } arb_state_e;
endpackage

// File: rtl/wb_arbiter_nto1_if.sv
// Wishbone classic bundle: N packed master ports on one side, a single slave port on the other.
interface wb_arbiter_nto1_if
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int DATA_W      = WB_DATA_W,
  parameter int SEL_W       = WB_SEL_W
);
  logic [NUM_MASTERS-1:0]        m_cyc;
  logic [NUM_MASTERS-1:0]        m_stb;
  logic [NUM_MASTERS-1:0]        m_we;
  logic [NUM_MASTERS*ADDR_W-1:0] m_adr;
  logic [NUM_MASTERS*DATA_W-1:0] m_dat_w;
  logic [NUM_MASTERS*SEL_W-1:0]  m_sel;
  logic [NUM_MASTERS-1:0]        m_ack;
  logic [NUM_MASTERS-1:0]        m_err;
  logic [DATA_W-1:0]             m_dat_r;

  logic              s_cyc;
  logic              s_stb;
  logic              s_we;
  logic [ADDR_W-1:0] s_adr;
  logic [DATA_W-1:0] s_dat_w;
  logic [SEL_W-1:0]  s_sel;
  logic              s_ack;
  logic              s_err;
  logic [DATA_W-1:0] s_dat_r;

  // Arbiter view: slave to the masters, master to the slave.
  modport arb (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
    output m_ack, m_err, m_dat_r,
    output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    input  s_ack, s_err, s_dat_r
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
    input  m_ack, m_err, m_dat_r
  );

  modport slave (
    input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    output s_ack, s_err, s_dat_r
  );
endinterface

// File: rtl/wb_arbiter_nto1_rr_pick.sv
// Combinational masked priority encoder: scans req from ptr upward (round-robin)
// or from index 0 (fixed priority) and returns the first set index.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  arb_mode_e     mode,
  output logic [IW-1:0] idx,
  output logic          vld
);
  localparam logic [IW:0] NN = (IW+1)'(N);

  logic [IW-1:0] base;
  logic [IW:0]   cand;

  // Scan from the far end so the candidate closest to base is written last.
  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    base = (mode == ARB_FIXED) ? '0 : ptr;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, base} + (IW+1)'(i);
      if (cand >= NN) cand = cand - NN;
      if (req[cand[IW-1:0]]) begin
        idx = cand[IW-1:0];
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter_nto1.sv
// N:1 Wishbone classic arbiter; owner held for the whole m_cyc, one idle cycle between owners.
// Optional hung-slave watchdog and ABORT state under WB_ARB_TIMEOUT_EN.
module wb_arbiter_nto1
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int DATA_W      = WB_DATA_W,
  parameter int SEL_W       = WB_SEL_W,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 256,
  localparam int IW         = $clog2(NUM_MASTERS)
) (
  input  logic           clk,
  input  logic           rst,
  wb_arbiter_nto1_if.arb bus,
  output logic [IW-1:0]  grant_id,
  output logic           busy
);
  localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

  arb_state_e    state, state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic          win_vld;
  logic          to_hit;

  logic own_cyc, own_stb, own_we;
  assign own_cyc = bus.m_cyc[grant_id];
  assign own_stb = bus.m_stb[grant_id];
  assign own_we  = bus.m_we[grant_id];

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req  (bus.m_cyc),
    .ptr  (ptr),
    .mode (MODE),
    .idx  (win),
    .vld  (win_vld)
  );

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          waiting;

  assign waiting = (state == BUSY) && own_cyc && own_stb && !bus.s_ack && !bus.s_err;
  assign to_hit  = waiting && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    to_cnt <= '0;
    else if (waiting && !to_hit) to_cnt <= to_cnt + 1'b1;
    else                        to_cnt <= '0;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_vld) begin
        grant_id <= win;
        ptr      <= (win == IW'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (win_vld) state_nxt = BUSY;
      BUSY: begin
        if (!own_cyc) state_nxt = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        else if (to_hit) state_nxt = ABORT;
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: if (!own_cyc) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.m_dat_r = bus.s_dat_r;

  always_comb begin
    busy        = (state != IDLE);
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_adr   = '0;
    bus.s_dat_w = '0;
    bus.s_sel   = '0;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    if (state == BUSY && !to_hit) begin
      bus.s_cyc           = own_cyc;
      bus.s_stb           = own_stb;
      bus.s_we            = own_we;
      bus.s_adr           = bus.m_adr[grant_id*ADDR_W +: ADDR_W];
      bus.s_dat_w         = bus.m_dat_w[grant_id*DATA_W +: DATA_W];
      bus.s_sel           = bus.m_sel[grant_id*SEL_W +: SEL_W];
      bus.m_ack[grant_id] = bus.s_ack;
      bus.m_err[grant_id] = bus.s_err;
    end
    if (to_hit) bus.m_err[grant_id] = 1'b1;
  end
endmodule

// File: tb/tb_wb_arbiter_nto1.sv
// Directed bench: round-robin instance and fixed-priority instance side by side.
module tb_wb_arbiter_nto1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] rr_gid, fx_gid;
  logic       rr_busy, fx_busy;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_nto1_if #(.NUM_MASTERS(4)) rr_if ();
  wb_arbiter_nto1_if #(.NUM_MASTERS(4)) fx_if ();

  wb_arbiter_nto1 #(
    .NUM_MASTERS(4), .ARB_MODE(0)
`ifdef WB_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) u_rr (.clk(clk), .rst(rst), .bus(rr_if), .grant_id(rr_gid), .busy(rr_busy));

  wb_arbiter_nto1 #(.NUM_MASTERS(4), .ARB_MODE(1))
    u_fx (.clk(clk), .rst(rst), .bus(fx_if), .grant_id(fx_gid), .busy(fx_busy));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    rr_if.m_cyc = '0; rr_if.m_stb = '0; rr_if.m_we = '0;
    rr_if.m_adr = '0; rr_if.m_dat_w = '0; rr_if.m_sel = '0;
    rr_if.s_ack = 1'b0; rr_if.s_err = 1'b0; rr_if.s_dat_r = '0;
    fx_if.m_cyc = '0; fx_if.m_stb = '0; fx_if.m_we = '0;
    fx_if.m_adr = '0; fx_if.m_dat_w = '0; fx_if.m_sel = '0;
    fx_if.s_ack = 1'b0; fx_if.s_err = 1'b0; fx_if.s_dat_r = '0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clr_inputs();
    rr_if.m_cyc = 4'b1111;
    rst = 1'b1;
    step();
    checks++; if (rr_if.s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", rr_if.s_cyc); end
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rr_busy); end
    checks++; if (rr_gid !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d want 0", rr_gid); end
    checks++; if (rr_if.m_ack !== 4'b0000) begin errors++; $display("FAIL reset_m_ack: got %b want 0000", rr_if.m_ack); end
  endtask

  task automatic test_single();
    do_reset();
    rr_if.m_cyc = 4'b0100; rr_if.m_stb = 4'b0100; rr_if.m_we = 4'b0100;
    rr_if.m_adr[2*32 +: 32] = 32'h10;
    rr_if.s_dat_r = 32'hCAFE_F00D;
    #1;
    checks++; if (rr_if.s_cyc !== 1'b0) begin errors++; $display("FAIL single_latency: s_cyc got %b want 0", rr_if.s_cyc); end
    step();
    checks++; if (rr_if.s_cyc !== 1'b1) begin errors++; $display("FAIL single_s_cyc: got %b want 1", rr_if.s_cyc); end
    checks++; if (rr_if.s_adr !== 32'h10) begin errors++; $display("FAIL single_s_adr: got %h want 00000010", rr_if.s_adr); end
    checks++; if (rr_if.s_we !== 1'b1) begin errors++; $display("FAIL single_s_we: got %b want 1", rr_if.s_we); end
    checks++; if (rr_gid !== 2'd2) begin errors++; $display("FAIL single_gid: got %0d want 2", rr_gid); end
    checks++; if (rr_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", rr_busy); end
    rr_if.s_ack = 1'b1;
    #1;
    checks++; if (rr_if.m_ack !== 4'b0100) begin errors++; $display("FAIL single_ack_route: got %b want 0100", rr_if.m_ack); end
    checks++; if (rr_if.m_dat_r !== 32'hCAFE_F00D) begin errors++; $display("FAIL single_dat_r: got %h want cafef00d", rr_if.m_dat_r); end
    step();
    rr_if.s_ack = 1'b0; rr_if.m_cyc = '0; rr_if.m_stb = '0;
    #1;
    checks++; if (rr_if.s_cyc !== 1'b0) begin errors++; $display("FAIL single_release_s_cyc: got %b want 0", rr_if.s_cyc); end
    checks++; if (rr_busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: got %b want 1", rr_busy); end
    step();
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL single_busy_clear: got %b want 0", rr_busy); end
  endtask

  task automatic test_rr_fairness();
    logic [3:0] one_hot;
    int exp;
    do_reset();
    rr_if.m_cyc = 4'b1111; rr_if.m_stb = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = k % 4;
      one_hot = 4'(1) << exp;
      #1;
      checks++; if (rr_if.s_cyc !== 1'b0) begin errors++; $display("FAIL rr_gap[%0d]: s_cyc got %b want 0", k, rr_if.s_cyc); end
      step();
      checks++; if (rr_gid !== 2'(exp)) begin errors++; $display("FAIL rr_order[%0d]: gid got %0d want %0d", k, rr_gid, exp); end
      checks++; if (rr_if.s_cyc !== 1'b1) begin errors++; $display("FAIL rr_s_cyc[%0d]: got %b want 1", k, rr_if.s_cyc); end
      rr_if.s_ack = 1'b1;
      rr_if.m_cyc[exp] = 1'b0;
      if (k == 3) rr_if.m_cyc[0] = 1'b1;
      #1;
      checks++; if (rr_if.m_ack !== one_hot) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", k, rr_if.m_ack, one_hot); end
      checks++; if (rr_if.s_cyc !== 1'b0) begin errors++; $display("FAIL rr_release[%0d]: s_cyc got %b want 0", k, rr_if.s_cyc); end
      step();
      rr_if.s_ack = 1'b0;
    end
  endtask

  task automatic test_fixed();
    do_reset();
    fx_if.m_cyc = 4'b1010; fx_if.m_stb = 4'b1010;
    step();
    checks++; if (fx_gid !== 2'd1) begin errors++; $display("FAIL fixed_first: gid got %0d want 1", fx_gid); end
    fx_if.s_ack = 1'b1; fx_if.m_cyc[1] = 1'b0;
    #1;
    checks++; if (fx_if.m_ack !== 4'b0010) begin errors++; $display("FAIL fixed_ack1: got %b want 0010", fx_if.m_ack); end
    step();
    fx_if.s_ack = 1'b0; fx_if.m_cyc[1] = 1'b1;
    step();
    checks++; if (fx_gid !== 2'd1) begin errors++; $display("FAIL fixed_rewin: gid got %0d want 1", fx_gid); end
    fx_if.s_ack = 1'b1; fx_if.m_cyc[1] = 1'b0; fx_if.m_stb[1] = 1'b0;
    step();
    fx_if.s_ack = 1'b0;
    step();
    checks++; if (fx_gid !== 2'd3) begin errors++; $display("FAIL fixed_low_prio: gid got %0d want 3", fx_gid); end
    fx_if.s_ack = 1'b1;
    #1;
    checks++; if (fx_if.m_ack !== 4'b1000) begin errors++; $display("FAIL fixed_ack3: got %b want 1000", fx_if.m_ack); end
    fx_if.s_ack = 1'b0; fx_if.m_cyc = '0; fx_if.m_stb = '0;
    step();
  endtask

  task automatic test_burst_hold();
    logic [31:0] exp_adr;
    do_reset();
    rr_if.m_cyc = 4'b0011; rr_if.m_stb = 4'b0011;
    step();
    for (int b = 0; b < 4; b++) begin
      exp_adr = 32'h100 + 32'(b * 4);
      rr_if.m_adr[0 +: 32] = exp_adr;
      rr_if.s_ack = 1'b1;
      #1;
      checks++; if (rr_gid !== 2'd0) begin errors++; $display("FAIL burst_gid[%0d]: got %0d want 0", b, rr_gid); end
      checks++; if (rr_if.m_ack !== 4'b0001) begin errors++; $display("FAIL burst_ack[%0d]: got %b want 0001", b, rr_if.m_ack); end
      checks++; if (rr_if.s_adr !== exp_adr) begin errors++; $display("FAIL burst_adr[%0d]: got %h want %h", b, rr_if.s_adr, exp_adr); end
      step();
    end
    rr_if.m_stb[0] = 1'b0;
    #1;
    checks++; if (rr_if.m_ack !== 4'b0001) begin errors++; $display("FAIL unqual_ack: got %b want 0001", rr_if.m_ack); end
    checks++; if (rr_if.s_stb !== 1'b0) begin errors++; $display("FAIL unqual_s_stb: got %b want 0", rr_if.s_stb); end
    rr_if.s_ack = 1'b0; rr_if.m_cyc[0] = 1'b0;
    step();
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL burst_gap_busy: got %b want 0", rr_busy); end
    step();
    checks++; if (rr_gid !== 2'd1) begin errors++; $display("FAIL burst_next_owner: gid got %0d want 1", rr_gid); end
    checks++; if (rr_if.s_cyc !== 1'b1) begin errors++; $display("FAIL burst_next_s_cyc: got %b want 1", rr_if.s_cyc); end
    rr_if.m_cyc = '0; rr_if.m_stb = '0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rr_if.m_cyc = 4'b0001; rr_if.m_stb = 4'b0001;
    step();
    checks++; if (rr_gid !== 2'd0) begin errors++; $display("FAIL rstmid_owner: gid got %0d want 0", rr_gid); end
    rr_if.m_cyc = 4'b0011; rr_if.m_stb = 4'b0011;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rr_if.s_cyc !== 1'b0) begin errors++; $display("FAIL rstmid_s_cyc: got %b want 0", rr_if.s_cyc); end
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", rr_busy); end
    checks++; if (rr_gid !== 2'd0) begin errors++; $display("FAIL rstmid_gid: got %0d want 0", rr_gid); end
    step();
    rst = 1'b0;
    step();
    checks++; if (rr_gid !== 2'd0) begin errors++; $display("FAIL rstmid_tie: gid got %0d want 0", rr_gid); end
    checks++; if (rr_if.s_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_regrant: s_cyc got %b want 1", rr_if.s_cyc); end
    rr_if.m_cyc = '0; rr_if.m_stb = '0;
    step();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    rr_if.m_cyc = 4'b0001; rr_if.m_stb = 4'b0001;
    step();
    for (int c = 0; c < 7; c++) begin
      checks++; if (rr_if.m_err !== 4'b0000) begin errors++; $display("FAIL to_early_err[%0d]: got %b want 0000", c, rr_if.m_err); end
      checks++; if (rr_if.s_cyc !== 1'b1) begin errors++; $display("FAIL to_s_cyc[%0d]: got %b want 1", c, rr_if.s_cyc); end
      step();
    end
    checks++; if (rr_if.m_err !== 4'b0001) begin errors++; $display("FAIL to_err_pulse: got %b want 0001", rr_if.m_err); end
    checks++; if (rr_if.s_cyc !== 1'b0) begin errors++; $display("FAIL to_force_low: s_cyc got %b want 0", rr_if.s_cyc); end
    step();
    rr_if.s_ack = 1'b1;
    #1;
    checks++; if (rr_if.m_err !== 4'b0000) begin errors++; $display("FAIL to_err_once: got %b want 0000", rr_if.m_err); end
    checks++; if (rr_if.m_ack !== 4'b0000) begin errors++; $display("FAIL to_abort_ignore: got %b want 0000", rr_if.m_ack); end
    checks++; if (rr_busy !== 1'b1) begin errors++; $display("FAIL to_abort_busy: got %b want 1", rr_busy); end
    rr_if.s_ack = 1'b0; rr_if.m_cyc = '0; rr_if.m_stb = '0;
    step();
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL to_idle: busy got %b want 0", rr_busy); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_rr_fairness();
    test_fixed();
    test_burst_hold();
    test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter_nto1.md
Name: wb_arbiter_nto1

Overview:
- Parametrised N-master to 1-slave Wishbone classic arbiter.
- Successor to the fixed-select 3:1 mux in the UART gateway. Selects the owner dynamically (round-robin or fixed priority) instead of using a static select.
- Holds ownership for the whole cycle (m_cyc) and optionally aborts hung slaves.
- Sits between the gateway agents (uart config, transfer handler, RC path) and the UART Wishbone slave.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16)
- ADDR_W, 32, Wishbone address width
- DATA_W, 32, Wishbone data width
- SEL_W, 4, byte-select width (DATA_W/8)
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority (index 0 highest)
- TIMEOUT_CYC, 256, watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- m_cyc  in  NUM_MASTERS  per-master cycle request
- m_stb  in  NUM_MASTERS  per-master strobe
- m_we  in  NUM_MASTERS  per-master write enable
- m_adr  in  NUM_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- m_dat_w  in  NUM_MASTERS*DATA_W  packed write data
- m_sel  in  NUM_MASTERS*SEL_W  packed byte selects
- m_ack  out  NUM_MASTERS  per-master ack
- m_err  out  NUM_MASTERS  per-master error
- m_dat_r  out  DATA_W  read data, broadcast to all masters
- s_cyc, s_stb, s_we  out  1  slave control
- s_adr  out  ADDR_W  slave address
- s_dat_w  out  DATA_W  slave write data
- s_sel  out  SEL_W  slave byte select
- s_ack, s_err  in  1  slave response
- s_dat_r  in  DATA_W  slave read data
- grant_id  out  $clog2(NUM_MASTERS)  current owner index
- busy  out  1  a master owns the bus

Behaviour:
- Reset state (async, on rst high):
  - All s_* outputs 0; m_ack, m_err, grant_id, busy all 0.
  - Round-robin pointer = 0; state IDLE.
  - Reset mid-transaction drops s_cyc immediately; no response is forwarded.
- FSM states: IDLE, BUSY, ABORT (ABORT exists only with the macro).
- IDLE:
  - If any m_cyc is high, pick a winner and register grant_id.
  - Set busy; go to BUSY.
  - Arbitration latency is 1 cycle: s_cyc is first high the cycle after the request is seen.
- Winner selection:
  - Round-robin: scan from the pointer upward, wrapping modulo NUM_MASTERS. On grant, pointer = winner+1 (wraps).
  - Fixed priority: lowest index with m_cyc high wins.
- BUSY, forwarding (combinational mux by grant_id):
  - s_cyc = m_cyc[g]; s_stb, s_we, s_adr, s_dat_w, s_sel from master g.
  - m_ack[g] = s_ack and m_err[g] = s_err; these are 0 for all other masters.
  - m_dat_r = s_dat_r, unregistered.
- BUSY, hold and release:
  - Grant is held across multiple strobes while m_cyc[g] stays high; other requests wait.
  - When m_cyc[g] falls, s_cyc falls the same cycle, the FSM goes to IDLE, and busy clears next cycle.
  - There is a minimum of 1 idle cycle between owners.
- s_ack or s_err arriving while s_stb is low is forwarded unqualified; the slave is responsible for protocol correctness.
- A master deasserting m_cyc in the same cycle as s_ack: the ack is still delivered and release happens.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- When defined:
  - A counter increments each BUSY cycle with s_stb high and no s_ack/s_err; it clears on any response or strobe low.
  - When it reaches TIMEOUT_CYC-1: pulse m_err[g] for 1 cycle, force s_cyc/s_stb to 0, enter ABORT.
  - ABORT holds s_cyc low and ignores the slave until m_cyc[g] falls, then returns to IDLE.
- When undefined: no counter and no ABORT state; the arbiter waits indefinitely for a response.

Decomposition:
- Package wb_arb_pkg holds:
  - arb_mode_e (ARB_RR=0, ARB_FIXED=1)
  - arb_state_e (IDLE, BUSY, ABORT)
  - default width constants, shared with uart_defines values
- Natural sub-module: rr_pick.
  - Combinational masked priority encoder: inputs are the request vector, pointer and mode; outputs are the winner index and a valid flag.
  - Reused by the gateway's future RC channel mux.

Test Plan:
- Single request: m_cyc[2]=1, stb, adr=0x10, we=1 → s_cyc high 1 cycle later, s_adr=0x10, grant_id=2; s_ack routed only to m_ack[2].
- RR fairness: m_cyc=4'b1111 held, each master drops cyc after one ack → grant order 0,1,2,3,0, with a 1-cycle idle gap between owners.
- Fixed priority (ARB_MODE=1): masters 1 and 3 request continuously → master 1 always wins; master 3 is granted only after master 1 releases with no other request pending.
- Burst hold: master 0 issues 4 strobes under one cyc while master 1 requests → grant_id stays 0 for all 4 acks; master 1 is granted after the release.
- Timeout (macro on, TIMEOUT_CYC=8): slave never acks → m_err[g] pulses 8 cycles after the strobe, s_cyc forced low, FSM returns to IDLE after m_cyc drops.
- Reset mid-transfer: rst asserted while BUSY with stb high → s_cyc, busy and grant_id are 0 asynchronously; after rst release, pointer=0 and master 0 wins a 0/1 tie.
